// File: rtl/shift_line_ctrl.sv
// Sequencing controller for a fixed-depth shift-register delay line: shift enable,
// per-stage valid tracking, flush/drain. Optional stall counter via SHIFT_LINE_STALL_CNT_EN.
module shift_line_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic             shift_en,
  output logic [CNT_W-1:0] occ,
  output logic             busy,
`ifdef SHIFT_LINE_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             flush_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] vbits_q, vbits_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             flush_done_q, flush_done_d;

  logic             tail_valid;
  logic             can_shift;
  logic             want_shift;
  logic             in_fire;

  function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      vbits_q      <= '0;
      occ_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      vbits_q      <= vbits_d;
      occ_q        <= occ_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Handshake and shift decode, derived from current state without added latency
  always_comb begin
    tail_valid = vbits_q[DEPTH-1];
    can_shift  = !tail_valid | out_ready;
    want_shift = (in_valid & (state_q != DRAIN))
               | (tail_valid & out_ready)
               | ((state_q == DRAIN) & (|vbits_q));
    shift_en   = can_shift & want_shift;
    in_ready   = can_shift & (state_q != DRAIN);
    in_fire    = in_valid & in_ready;
    out_valid  = tail_valid;
    busy       = (state_q != IDLE);
    occ        = occ_q;
    flush_done = flush_done_q;
  end

  // Next-state: valid-bit shifting and sequencing
  always_comb begin
    vbits_d      = vbits_q;
    state_d      = state_q;
    flush_done_d = 1'b0;
    if (shift_en) begin
      vbits_d = {vbits_q[DEPTH-2:0], in_fire};
    end
    occ_d = popcount(vbits_d);
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          state_d = flush ? DRAIN : RUN;
        end else if (flush) begin
          flush_done_d = 1'b1;
        end
      end
      RUN: begin
        if (flush) begin
          // An already-empty line completes its flush without visiting DRAIN
          if (vbits_d == '0) begin
            state_d      = IDLE;
            flush_done_d = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end else if (vbits_d == '0) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (vbits_d == '0) begin
          state_d      = IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef SHIFT_LINE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where the tail is held back by downstream
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (flush_done_d) begin
      stall_cnt_d = '0;
    end else if (tail_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
